// File: rtl/rc4_stream_if.sv
// rc4_stream_if: host-side valid/ready stream pair (input words in, XORed words out)
//   in_data/in_valid  host -> controller word stream, in_ready is the controller's accept
//   out_data/out_valid controller -> sink word stream, out_ready is the sink's accept
interface rc4_stream_if #(parameter int N = 24) ();
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl: sequences one RC4 keystream core and XORs a host stream with its keystream
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        session control; password captured when start is accepted
//   busy, done, error   status; done pulses on completion, error is sticky on init timeout
//   word_count          words accepted this session, saturating at MAX_WORDS
//   s                   host stream (slave side of rc4_stream_if)
//   core_*              RC4 core control: clear, password, init handshake, keystream pop
module rc4_stream_ctrl #(
    parameter int N            = 24,
    parameter int MAX_WORDS    = 4096,
    parameter int INIT_TIMEOUT = 1024,
    parameter int CLR_CYCLES   = 2,
    localparam int WW          = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  password,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [WW-1:0] word_count,
    rc4_stream_if.slave   s,
    output logic          core_clr,
    output logic [N-1:0]  core_password,
    input  logic          core_init_done,
    input  logic [N-1:0]  core_k,
    input  logic          core_k_valid,
    output logic          core_k_take
);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam int TW = $clog2(INIT_TIMEOUT + 1);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT_INIT = 3'd2,
                           STREAM = 3'd3, DRAIN = 3'd4, ERROR = 3'd5;
    logic [2:0]    state, nxt;
    logic [CW-1:0] clr_cnt;
    logic [TW-1:0] timer;
    logic          accept, start_acc;
    assign busy        = state != IDLE;
    assign start_acc   = state == IDLE && start && !abort;
    assign s.in_ready  = state == STREAM && !abort && core_k_valid &&
                         (!s.out_valid || s.out_ready) && word_count < WW'(MAX_WORDS);
    assign accept      = s.in_valid && s.in_ready;
    assign core_k_take = accept;
    // The core is only released while a session is actually using it
    assign core_clr    = abort || !(state == WAIT_INIT || state == STREAM || state == DRAIN);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start ? LOAD : IDLE;
            LOAD:      nxt = clr_cnt == CW'(CLR_CYCLES - 1) ? WAIT_INIT : LOAD;
            WAIT_INIT: nxt = core_init_done ? STREAM : timer == TW'(INIT_TIMEOUT - 1) ? ERROR : WAIT_INIT;
            STREAM:    nxt = accept && word_count == WW'(MAX_WORDS - 1) ? DRAIN : STREAM;
            DRAIN:     nxt = s.out_valid ? DRAIN : IDLE;
            default:   nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            timer         <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            word_count    <= '0;
            core_password <= '0;
            s.out_valid   <= 1'b0;
            s.out_data    <= '0;
        end else begin
            state   <= nxt;
            clr_cnt <= state == LOAD ? clr_cnt + CW'(1) : '0;
            timer   <= state == WAIT_INIT ? timer + TW'(1) : '0;
            done    <= state == DRAIN && !s.out_valid && !abort;
            error   <= start_acc ? 1'b0 : nxt == ERROR ? 1'b1 : error;
            if (start_acc) begin
                core_password <= password;
                word_count    <= '0;
            end else if (accept) begin
                word_count    <= word_count + WW'(1);
            end
            // A new accept replaces a word being handed off in the same cycle
            if (abort) begin
                s.out_valid <= 1'b0;
            end else if (accept) begin
                s.out_valid <= 1'b1;
                s.out_data  <= s.in_data ^ core_k;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end
endmodule
